// File: rtl/fp_sp_pkg.sv
// Shared single-precision definitions used by the integer encoder and the adder.
package fp_sp_pkg;

    localparam int INT_W       = 32;
    localparam int SP_EXP_W    = 8;
    localparam int SP_FRAC_W   = 23;
    localparam int SP_EXP_BIAS = 127;

    // IEEE-754 single-precision word, MSB first.
    typedef struct packed {
        logic                 sign;
        logic [SP_EXP_W-1:0]  exp;
        logic [SP_FRAC_W-1:0] frac;
    } sp_word_t;

endpackage

// File: rtl/fp_int_to_sp_encoder_lzd32.sv
// Combinational 32-bit leading-one detector: index of the highest set bit.
module lzd32 (
    input  logic [31:0] value,
    output logic [4:0]  msb,
    output logic        zero
);

    // Scan upward so the highest set bit wins; index is 0 when value is 0.
    always_comb begin
        msb = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                msb = 5'(i);
            end
        end
    end

    assign zero = ~|value;

endmodule

// File: rtl/fp_int_to_sp_encoder.sv
// 4-stage signed int32 -> IEEE-754 single converter, round to nearest even.
//
// Handshake: an operand is accepted on a rising edge where in_valid && in_ready;
// a result is transferred on a rising edge where out_valid && out_ready. All
// stages shift together when advance = !out_valid || out_ready, and
// in_ready = advance, so a held output freezes the whole pipe and blocks input.
module fp_int_to_sp_encoder
    import fp_sp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_int,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_fp,
    output logic             out_inexact
);

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // S1: sign and unsigned magnitude (-2^31 maps to 0x80000000).
    logic             s1_valid;
    logic             s1_sign;
    logic [INT_W-1:0] s1_mag;

    // S1 valid bit follows the input handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
        end
    end

    // S1 data: two's-complement negate when negative.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_sign <= in_int[INT_W-1];
            s1_mag  <= in_int[INT_W-1] ? (~in_int + 32'd1) : in_int;
        end
    end

    // S2: leading-one position of the magnitude.
    logic [4:0]       lzd_msb;
    logic             lzd_zero;
    logic             s2_valid;
    logic             s2_sign;
    logic [INT_W-1:0] s2_mag;
    logic [4:0]       s2_msb;
    logic             s2_zero;

    lzd32 u_lzd (
        .value (s1_mag),
        .msb   (lzd_msb),
        .zero  (lzd_zero)
    );

    // S2 valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
        end
    end

    // S2 data: carry magnitude alongside its leading-one index.
    always_ff @(posedge clk) begin
        if (advance) begin
            s2_sign <= s1_sign;
            s2_mag  <= s1_mag;
            s2_msb  <= lzd_msb;
            s2_zero <= lzd_zero;
        end
    end

    // S3: normalise so the leading one sits at bit 31 (dropped as hidden bit).
    logic [30:0]          norm;
    logic                 s3_valid;
    logic                 s3_sign;
    logic                 s3_zero;
    logic [SP_EXP_W-1:0]  s3_exp;
    logic [SP_FRAC_W-1:0] s3_frac;
    logic                 s3_guard;
    logic                 s3_sticky;

    assign norm = 31'(s2_mag << (5'd31 - s2_msb));

    // S3 valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid <= 1'b0;
        end else if (advance) begin
            s3_valid <= s2_valid;
        end
    end

    // S3 data: split normalised magnitude into fraction, guard and sticky.
    always_ff @(posedge clk) begin
        if (advance) begin
            s3_sign   <= s2_sign;
            s3_zero   <= s2_zero;
            s3_exp    <= 8'(SP_EXP_BIAS) + {3'd0, s2_msb};
            s3_frac   <= norm[30:8];
            s3_guard  <= norm[7];
            s3_sticky <= |norm[6:0];
        end
    end

    // S4: round to nearest even; a fraction carry-out bumps the exponent.
    logic                round_up;
    logic [SP_FRAC_W:0]  frac_rnd;
    logic [SP_EXP_W-1:0] exp_rnd;
    sp_word_t            packed_word;

    // Round-and-pack, with integer zero forced to +0.
    always_comb begin
        round_up    = s3_guard & (s3_sticky | s3_frac[0]);
        frac_rnd    = {1'b0, s3_frac} + {23'd0, round_up};
        exp_rnd     = s3_exp + {7'd0, frac_rnd[SP_FRAC_W]};
        packed_word = '0;
        if (!s3_zero) begin
            packed_word.sign = s3_sign;
            packed_word.exp  = exp_rnd;
            packed_word.frac = frac_rnd[SP_FRAC_W-1:0];
        end
    end

    // Output register: loads only on advance so held results stay stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_fp      <= 32'h0000_0000;
            out_inexact <= 1'b0;
        end else if (advance) begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                out_fp      <= packed_word;
                out_inexact <= !s3_zero && (s3_guard | s3_sticky);
            end
        end
    end

endmodule

// File: tb/tb_fp_int_to_sp_encoder.sv
// Bench for fp_int_to_sp_encoder: directed values, backpressure, reset
// mid-stream and a randomized regression against an arithmetic model.
module tb_fp_int_to_sp_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_int;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;
    logic        out_inexact;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit lat_check = 1'b0;
    bit drv_done  = 1'b0;

    // Expected {inexact, fp}, with acceptance cycle and operand alongside.
    logic [32:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] in_q[$];

    fp_int_to_sp_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_int      (in_int),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_fp      (out_fp),
        .out_inexact (out_inexact)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer arithmetic, rounding by remainder against half.
    function automatic logic [32:0] model(input logic [31:0] v);
        logic        sign;
        logic [63:0] m, q, r, half;
        int          e, sh;
        logic        inexact;
        sign = v[31];
        m = sign ? 64'(-$signed({32'hFFFF_FFFF, v})) : {32'd0, v};
        if (m == 0) return 33'd0;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        inexact = 1'b0;
        if (e <= 23) begin
            q = m << (23 - e);
        end else begin
            sh   = e - 23;
            q    = m >> sh;
            r    = m - (q << sh);
            half = 64'd1 << (sh - 1);
            if (r > half || (r == half && q[0])) q = q + 1;
            inexact = (r != 0);
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        return {inexact, sign, 8'(e + 127), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_int();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = $urandom;
            1: v = $urandom_range(0, 255);
            2: v = 32'h0100_0000 + $urandom_range(0, 7);
            3: case ($urandom_range(0, 3))
                   0: v = 32'h7FFF_FFFF;
                   1: v = 32'h8000_0000;
                   2: v = 32'h0;
                   default: v = 32'h00FF_FFFF;
               endcase
            default: v = $urandom >> $urandom_range(0, 31);
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    // Driver: present one operand from posedge+1 until it is accepted.
    task automatic drive_one(input logic [31:0] v, input logic [32:0] e);
        bit acc = 1'b0;
        in_int   = v;
        in_valid = 1'b1;
        for (int w = 0; w < 500 && !acc; w++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                exp_q.push_back(e);
                lat_q.push_back(cyc);
                in_q.push_back(v);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout in=%h never accepted", v);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor: pop and compare on every transferred result.
    always @(negedge clk) begin
        logic [32:0] e;
        logic [31:0] v;
        int          t;
        if (!reset && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output actual=%h/%0b required=none", out_fp, out_inexact);
            end else begin
                e = exp_q.pop_front();
                t = lat_q.pop_front();
                v = in_q.pop_front();
                if (out_fp !== e[31:0] || out_inexact !== e[32]) begin
                    n_fail++;
                    $display("FAIL result in=%h actual=%h/%0b required=%h/%0b",
                             v, out_fp, out_inexact, e[31:0], e[32]);
                end
                if (lat_check) begin
                    n_tests++;
                    if (cyc - t != 4) begin
                        n_fail++;
                        $display("FAIL latency in=%h actual=%0d required=4", v, cyc - t);
                    end
                end
            end
        end
    end

    logic [31:0] dir_in  [8] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF,
                                 32'h8000_0000, 32'd16777217, 32'd16777219, 32'd100};
    logic [32:0] dir_exp [8] = '{{1'b0, 32'h3F80_0000}, {1'b0, 32'hBF80_0000},
                                 {1'b0, 32'h0000_0000}, {1'b1, 32'h4F00_0000},
                                 {1'b0, 32'hCF00_0000}, {1'b1, 32'h4B80_0000},
                                 {1'b1, 32'h4B80_0002}, {1'b0, 32'h42C8_0000}};

    initial begin
        logic [31:0] held;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_int    = '0;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_fp", out_fp, 32'h0);
        check("reset_out_inexact", {31'd0, out_inexact}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Directed values back to back, with latency checking.
        lat_check = 1'b1;
        for (int i = 0; i < 8; i++) drive_one(dir_in[i], dir_exp[i]);
        idle(8);
        lat_check = 1'b0;

        // Backpressure: hold out_ready low for 5 cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [31:0] v;
                    v = rand_int();
                    drive_one(v, model(v));
                end
            end
            begin
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (i == 0) held = out_fp;
                    else check("hold_out_fp", out_fp, held);
                    check("hold_out_valid", {31'd0, out_valid}, 32'd1);
                    check("hold_in_ready", {31'd0, in_ready}, 32'd0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        idle(10);
        check("bp_drained", exp_q.size(), 32'd0);

        // Reset with 3 operands in flight, then one fresh operand.
        drive_one(32'd5, model(32'd5));
        drive_one(-32'd7, model(-32'd7));
        drive_one(32'd123456789, model(32'd123456789));
        reset = 1'b1;
        exp_q.delete();
        lat_q.delete();
        in_q.delete();
        @(posedge clk);
        #1;
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_out_fp", out_fp, 32'h0);
        reset = 1'b0;
        lat_check = 1'b1;
        drive_one(32'd100, {1'b0, 32'h42C8_0000});
        idle(10);
        lat_check = 1'b0;
        check("midreset_single_result", exp_q.size(), 32'd0);

        // Random regression with random input gaps and output stalls.
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20000; i++) begin
                    logic [31:0] v;
                    v = rand_int();
                    drive_one(v, model(v));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        for (int w = 0; w < 1000 && exp_q.size() != 0; w++) begin
            @(posedge clk);
            #1;
        end
        check("final_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
